// File: rtl/comparator_serial_4b_pkg.sv
// Shared types and flag encodings for the serial nibble-wise magnitude comparator.
// Flag vectors are ordered {l, g, m}: l = A<B, g = A==B, m = A>B.
package comparator_serial_4b_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b001;

endpackage

// File: rtl/comparator_serial_4b_cmp.sv
// 4-bit magnitude comparator with l/g/m cascade inputs.
// An unequal nibble decides the result; an equal nibble passes the cascade through.
module comparator_4b
  import comparator_serial_4b_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       l_in,
  input  logic       g_in,
  input  logic       m_in,
  output logic       l,
  output logic       g,
  output logic       m
);

  always_comb begin
    if (a < b) begin
      {l, g, m} = CMP_LT;
    end else if (a > b) begin
      {l, g, m} = CMP_GT;
    end else begin
      {l, g, m} = {l_in, g_in, m_in};
    end
  end

endmodule

// File: rtl/comparator_serial_4b.sv
// Serial multi-nibble magnitude comparator: operands arrive LSB nibble first, the
// running decision is kept in an accumulator fed back through comparator_4b's cascade.
module comparator_serial_4b
  import comparator_serial_4b_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       nib_valid,
  output logic       nib_ready,
  input  logic [3:0] a_nib,
  input  logic [3:0] b_nib,
  output logic       busy,
  output logic       done,
  output logic       l,
  output logic       g,
  output logic       m
);

  localparam int                CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       acc_q, acc_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;
  logic [2:0]       cmp_out;
  logic             hs;

  comparator_4b u_cmp (
    .a    (a_nib),
    .b    (b_nib),
    .l_in (acc_q[2]),
    .g_in (acc_q[1]),
    .m_in (acc_q[0]),
    .l    (cmp_out[2]),
    .g    (cmp_out[1]),
    .m    (cmp_out[0])
  );

  // busy and nib_ready are decoded straight from the state flop, so they stay glitch-free.
  assign busy      = (state_q == ST_RUN);
  assign nib_ready = (state_q == ST_RUN);
  assign hs        = nib_valid & nib_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = CMP_EQ;
        end
      end
      ST_RUN: begin
        if (hs) begin
          acc_d = cmp_out;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            res_d   = cmp_out;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= CMP_EQ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= 3'b000;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign {l, g, m} = res_q;

endmodule

// File: tb/tb_comparator_serial_4b.sv
// Directed bench for comparator_serial_4b: a 4-nibble instance driven from a vector
// table plus hand-written corner sequences, and a 1-nibble instance swept exhaustively.
module tb_comparator_serial_4b;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp_lgm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, nib_valid;
  logic [3:0] a_nib, b_nib;
  logic       nib_ready, busy, done, l, g, m;

  logic       start1, valid1;
  logic [3:0] a1, b1;
  logic       ready1, busy1, done1, l1, g1, m1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  comparator_serial_4b #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nib_valid (nib_valid),
    .nib_ready (nib_ready),
    .a_nib     (a_nib),
    .b_nib     (b_nib),
    .busy      (busy),
    .done      (done),
    .l         (l),
    .g         (g),
    .m         (m)
  );

  comparator_serial_4b #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .nib_valid (valid1),
    .nib_ready (ready1),
    .a_nib     (a1),
    .b_nib     (b1),
    .busy      (busy1),
    .done      (done1),
    .l         (l1),
    .g         (g1),
    .m         (m1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one 4-nibble compare. cycles counts the start cycle as 1 through the done cycle.
  // gap: idle cycles inserted after nibble 0 and after nibble 1.
  // pre_started: start was already driven in the current cycle by the previous call.
  // chain: drive start in the done cycle. poke_start: pulse start in the second RUN cycle.
  task automatic do_compare(input logic [15:0] a, input logic [15:0] b, input int gap,
                            input bit pre_started, input bit chain, input bit poke_start,
                            output logic [2:0] res, output int cycles);
    int idx   = 0;
    int stall = 0;
    bit seen  = 0;
    res = 3'b000;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    cycles = 1;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (poke_start && cycles == 3) start = 1'b1;
      if (done) begin
        seen      = 1;
        res       = {l, g, m};
        nib_valid = 1'b0;
        if (chain) start = 1'b1;
      end else if (busy && idx < 4) begin
        if (stall > 0) begin
          check("ready_while_stalled", 32'(nib_ready), 32'd1);
          nib_valid = 1'b0;
          stall--;
        end else begin
          check("ready_in_run", 32'(nib_ready), 32'd1);
          nib_valid = 1'b1;
          a_nib     = a[idx*4 +: 4];
          b_nib     = b[idx*4 +: 4];
          idx++;
          if (idx == 1 || idx == 2) stall = gap;
        end
      end else begin
        nib_valid = 1'b0;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [2:0]  res;
    int          cyc;

    vecs[0] = '{16'h1234, 16'h1234, EQ};
    vecs[1] = '{16'h8000, 16'h7FFF, GT};
    vecs[2] = '{16'h00F0, 16'h00F1, LT};
    vecs[3] = '{16'hFFFF, 16'h0000, GT};
    vecs[4] = '{16'h0000, 16'h0001, LT};
    vecs[5] = '{16'hA5A5, 16'hA5A4, GT};
    vecs[6] = '{16'h1000, 16'h0FFF, GT};
    vecs[7] = '{16'h0FFF, 16'h1000, LT};

    rst_n = 1'b0; start = 1'b0; nib_valid = 1'b0; a_nib = '0; b_nib = '0;
    start1 = 1'b0; valid1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(nib_ready), 32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_lgm",   32'({l, g, m}), 32'd0);
    check("rst1_all",  32'({busy1, ready1, done1, l1, g1, m1}), 32'd0);
    rst_n = 1'b1;

    // Main table: nib_valid held whenever ready, done in cycle NIBBLES+2.
    for (int i = 0; i < 8; i++) begin
      do_compare(vecs[i].a, vecs[i].b, 0, 0, 0, 0, res, cyc);
      check($sformatf("vec%0d_lgm", i), 32'(res), 32'(vecs[i].exp_lgm));
      check($sformatf("vec%0d_latency", i), cyc, 32'd6);
    end

    // Asynchronous reset between clock edges clears the held result at once.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lgm",  32'({l, g, m}), 32'd0);
    check("async_rst_busy", 32'({busy, nib_ready, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stalls of three cycles after nibbles 0 and 1 add exactly six cycles.
    do_compare(16'h5A5A, 16'h5A5B, 3, 0, 0, 0, res, cyc);
    check("stall_lgm",     32'(res), 32'(LT));
    check("stall_latency", cyc,      32'd12);

    // Reset after two handshakes; the next compare must not inherit anything.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; nib_valid = 1'b1; a_nib = 4'h1; b_nib = 4'h2;
    @(negedge clk); a_nib = 4'h3; b_nib = 4'h0;
    @(negedge clk); nib_valid = 1'b0;
    check("mid_run_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({busy, nib_ready, done, l, g, m}), 32'd0);
    @(negedge clk);
    check("mid_rst_held", 32'({busy, nib_ready, done, l, g, m}), 32'd0);
    rst_n = 1'b1;
    do_compare(16'hFFFF, 16'h0000, 0, 0, 0, 0, res, cyc);
    check("post_rst_lgm",     32'(res), 32'(GT));
    check("post_rst_latency", cyc,      32'd6);

    // start pulsed during RUN is ignored; start in the done cycle chains with no gap.
    do_compare(16'h1111, 16'h2222, 0, 0, 1, 1, res, cyc);
    check("poke_lgm",     32'(res), 32'(LT));
    check("poke_latency", cyc,      32'd6);
    do_compare(16'h3333, 16'h3333, 0, 1, 0, 0, res, cyc);
    check("chain_lgm",     32'(res), 32'(EQ));
    check("chain_latency", cyc,      32'd6);

    // NIBBLES=1 exhaustive sweep: done lands two cycles after start.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [2:0] exp;
        exp = (a < b) ? LT : ((a == b) ? EQ : GT);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; valid1 = 1'b1; a1 = 4'(a); b1 = 4'(b);
        @(negedge clk); valid1 = 1'b0;
        check($sformatf("sweep_%0d_%0d", a, b), 32'({done1, l1, g1, m1}), 32'({1'b1, exp}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
